mii_rx_deframer: RTL and testbench

MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

---
 rtl/mii_pkg.sv | 22 ++
 rtl/mii_rx_deframer_if.sv | 9 +
 rtl/mii_nibble_pack.sv | 49 ++++
 rtl/mii_rx_deframer.sv | 191 +++++++++++++++++++
 tb/tb_mii_rx_deframer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mii_pkg.sv
// Shared types and constants for the MII receive deframer.
// FSM encoding, framing nibbles, header length, rx_err bit positions.
package mii_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        PREAMBLE  = 3'd2,
        HDR       = 3'd3,
        PAYLOAD   = 3'd4,
        DROP      = 3'd5
    } state_t;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;
    localparam int         HDR_BYTES    = 14;

    localparam int ERR_RUNT  = 0;
    localparam int ERR_ALIGN = 1;
    localparam int ERR_LONG  = 2;

endpackage

// File: rtl/mii_rx_deframer_if.sv
// MII receive nibble stream: data-valid plus 4-bit nibble.
// The PHY side drives it, the receiver side samples it.
interface mii_rx_deframer_if;
    logic       en;
    logic [3:0] d;

    modport master (output en, output d);
    modport slave  (input  en, input  d);
endinterface

// File: rtl/mii_nibble_pack.sv
// Nibble-to-byte assembler, low nibble first on the wire.
// Tracks the alignment phase so a dangling nibble can be reported.
module mii_nibble_pack
    import mii_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     take_i,
    mii_rx_deframer_if.slave         mii_i,
    output logic [7:0]               byte_o,
    output logic                     done_o,
    output logic                     pending_o
);

    logic       phase_q, phase_d;
    logic [3:0] lo_q, lo_d;
    logic       acc;

    assign acc       = take_i & mii_i.en;
    assign done_o    = acc & phase_q;
    assign byte_o    = {mii_i.d, lo_q};
    assign pending_o = phase_q;

    // Next phase / held low nibble.
    always_comb begin
        phase_d = phase_q;
        lo_d    = lo_q;
        if (clr_i) begin
            phase_d = 1'b0;
            lo_d    = 4'h0;
        end else if (acc) begin
            phase_d = ~phase_q;
            if (!phase_q) lo_d = mii_i.d;
        end
    end

    // Phase and low-nibble registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
            lo_q    <= 4'h0;
        end else begin
            phase_q <= phase_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: preamble/SFD hunt, header capture, payload
// byte strobes and end-of-frame status with length and error flags.
module mii_rx_deframer
    import mii_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        mii0_clk,
    input  logic        rst_n,
    input  logic        mii0_en,
    input  logic [3:0]  mii0_d,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type,
    output logic        hdr_valid,
    output logic        rx_eof,
    output logic [10:0] rx_len,
    output logic [2:0]  rx_err
);

    localparam logic [10:0] MAX_C = 11'(MAX_LEN);
    localparam logic [10:0] SAT_C = 11'(MAX_LEN + 1);
    localparam logic [10:0] MIN_C = 11'(MIN_LEN);
    localparam logic [10:0] HDR_L = 11'(HDR_BYTES - 1);

    mii_rx_deframer_if nib_if ();
    assign nib_if.en = mii0_en;
    assign nib_if.d  = mii0_d;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        sfd_q, sfd_d;
    logic        long_q, long_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [7:0]  rxb_q, rxb_d;
    logic        rxv_q, rxv_d, hdrv_q, hdrv_d, eof_q, eof_d;
    logic [10:0] len_q, len_d;
    logic [2:0]  err_q, err_d;
    logic        clr, take, done, pend;
    logic [7:0]  nb;

    mii_nibble_pack u_pack (
        .clk_i     (mii0_clk),
        .rst_ni    (rst_n),
        .clr_i     (clr),
        .take_i    (take),
        .mii_i     (nib_if),
        .byte_o    (nb),
        .done_o    (done),
        .pending_o (pend)
    );

    // Next state, field capture and output strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sfd_d   = sfd_q;
        long_d  = long_q;
        dst_d   = dst_q;
        src_d   = src_q;
        type_d  = type_q;
        rxb_d   = rxb_q;
        rxv_d   = 1'b0;
        hdrv_d  = 1'b0;
        eof_d   = 1'b0;
        len_d   = len_q;
        err_d   = err_q;
        clr     = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            WAIT_IDLE: begin
                if (!mii0_en) state_d = IDLE;
            end
            IDLE: begin
                sfd_d  = 1'b0;
                long_d = 1'b0;
                if (mii0_en)
                    state_d = (mii0_d == PREAMBLE_NIB) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!mii0_en) begin
                    state_d = IDLE;
                end else if (mii0_d == SFD_NIB) begin
                    state_d = HDR;
                    clr     = 1'b1;
                    cnt_d   = 11'd0;
                    sfd_d   = 1'b1;
                    long_d  = 1'b0;
                end else if (mii0_d != PREAMBLE_NIB) begin
                    state_d = DROP;
                end
            end
            HDR, PAYLOAD: begin
                take = 1'b1;
                if (!mii0_en) begin
                    state_d          = IDLE;
                    eof_d            = 1'b1;
                    len_d            = cnt_q;
                    err_d            = 3'b000;
                    err_d[ERR_LONG]  = long_q;
                    err_d[ERR_ALIGN] = pend;
                    err_d[ERR_RUNT]  = cnt_q < MIN_C;
                end else if (done) begin
                    if (cnt_q == MAX_C) begin
                        long_d  = 1'b1;
                        cnt_d   = SAT_C;
                        state_d = DROP;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                        if (state_q == HDR) begin
                            if (cnt_q < 11'd6)
                                dst_d = {dst_q[39:0], nb};
                            else if (cnt_q < 11'd12)
                                src_d = {src_q[39:0], nb};
                            else
                                type_d = {type_q[7:0], nb};
                            if (cnt_q == HDR_L) begin
                                hdrv_d  = 1'b1;
                                state_d = PAYLOAD;
                            end
                        end else begin
                            rxb_d = nb;
                            rxv_d = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (!mii0_en) begin
                    state_d = IDLE;
                    if (sfd_q) begin
                        eof_d           = 1'b1;
                        len_d           = cnt_q;
                        err_d           = 3'b000;
                        err_d[ERR_LONG] = long_q;
                        err_d[ERR_RUNT] = cnt_q < MIN_C;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // State, counters, captured fields and registered outputs.
    always_ff @(posedge mii0_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
            cnt_q   <= '0;
            sfd_q   <= 1'b0;
            long_q  <= 1'b0;
            dst_q   <= '0;
            src_q   <= '0;
            type_q  <= '0;
            rxb_q   <= '0;
            rxv_q   <= 1'b0;
            hdrv_q  <= 1'b0;
            eof_q   <= 1'b0;
            len_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sfd_q   <= sfd_d;
            long_q  <= long_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            type_q  <= type_d;
            rxb_q   <= rxb_d;
            rxv_q   <= rxv_d;
            hdrv_q  <= hdrv_d;
            eof_q   <= eof_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign rx_byte   = rxb_q;
    assign rx_valid  = rxv_q;
    assign dst_mac   = dst_q;
    assign src_mac   = src_q;
    assign eth_type  = type_q;
    assign hdr_valid = hdrv_q;
    assign rx_eof    = eof_q;
    assign rx_len    = len_q;
    assign rx_err    = err_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Testbench for mii_rx_deframer: directed and random frames
// checked against a frame-level reference model.
module tb_mii_rx_deframer;
    import mii_pkg::*;

    localparam int MAXL = 1518;
    localparam int MINL = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_byte;
    logic        rx_valid, hdr_valid, rx_eof;
    logic [47:0] dst_mac, src_mac;
    logic [15:0] eth_type;
    logic [10:0] rx_len;
    logic [2:0]  rx_err;

    always #5 clk = ~clk;

    mii_rx_deframer_if bus ();

    mii_rx_deframer #(.MAX_LEN(MAXL), .MIN_LEN(MINL)) dut (
        .mii0_clk  (clk),
        .rst_n     (rst_n),
        .mii0_en   (bus.en),
        .mii0_d    (bus.d),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .dst_mac   (dst_mac),
        .src_mac   (src_mac),
        .eth_type  (eth_type),
        .hdr_valid (hdr_valid),
        .rx_eof    (rx_eof),
        .rx_len    (rx_len),
        .rx_err    (rx_err)
    );

    int nchk = 0;
    int nerr = 0;

    logic [7:0]  got_q[$];
    int          hdr_n = 0, eof_n = 0, clash_n = 0;
    logic [10:0] eof_len;
    logic [2:0]  eof_err;

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_byte);
        if (hdr_valid) hdr_n++;
        if (rx_eof) begin
            eof_n++;
            eof_len = rx_len;
            eof_err = rx_err;
        end
        if (rx_valid && rx_eof) clash_n++;
    end

    logic [7:0]  fr[$];
    logic [7:0]  exp_pl[$];
    int          exp_len, exp_hdr;
    logic [2:0]  exp_err;
    logic [47:0] exp_dst, exp_src;
    logic [15:0] exp_type;
    int          snap_h, snap_e, snap_p;
    int          h0, e0;

    task automatic nib(input logic e, input logic [3:0] v);
        bus.en = e;
        bus.d  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    endtask

    task automatic send(input bit odd, input int rst_at);
        for (int i = 0; i < 15; i++) nib(1'b1, PREAMBLE_NIB);
        nib(1'b1, SFD_NIB);
        foreach (fr[i]) begin
            if (i == rst_at) rst_n = 1'b0;
            nib(1'b1, fr[i][3:0]);
            nib(1'b1, fr[i][7:4]);
            if (i == rst_at) begin
                rst_n  = 1'b1;
                snap_h = hdr_n;
                snap_e = eof_n;
                snap_p = got_q.size();
            end
        end
        if (odd) nib(1'b1, 4'($urandom));
        for (int i = 0; i < 8; i++) nib(1'b0, 4'h0);
    endtask

    // Frame-level expectation straight from the framing rules.
    task automatic model(input int n, input bit odd);
        int lim;
        lim      = (n > MAXL) ? MAXL : n;
        exp_len  = (n > MAXL) ? MAXL + 1 : n;
        exp_err  = 3'b000;
        exp_err[ERR_LONG]  = n > MAXL;
        exp_err[ERR_ALIGN] = odd && (n <= MAXL);
        exp_err[ERR_RUNT]  = exp_len < MINL;
        exp_hdr  = (n >= 14) ? 1 : 0;
        exp_pl.delete();
        for (int i = 14; i < lim; i++) exp_pl.push_back(fr[i]);
        exp_dst  = '0;
        exp_src  = '0;
        exp_type = '0;
        if (n >= 14) begin
            for (int i = 0; i < 6; i++) begin
                exp_dst = {exp_dst[39:0], fr[i]};
                exp_src = {exp_src[39:0], fr[i+6]};
            end
            exp_type = {fr[12], fr[13]};
        end
    endtask

    function automatic int pl_diff();
        int d;
        d = (got_q.size() == exp_pl.size()) ? 0 : 1;
        if (d == 0)
            foreach (exp_pl[i]) if (got_q[i] !== exp_pl[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        bus.en = 1'b1;
        bus.d  = PREAMBLE_NIB;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchk++;
        if ({rx_valid, hdr_valid, rx_eof} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_strobes got %b exp 000",
                     {rx_valid, hdr_valid, rx_eof});
        end
        nchk++;
        if ({rx_len, rx_err, rx_byte} !== 22'd0) begin
            nerr++;
            $display("FAIL reset_status got len=%0d err=%b byte=%h exp 0",
                     rx_len, rx_err, rx_byte);
        end
        nchk++;
        if ({dst_mac, src_mac, eth_type} !== 112'd0) begin
            nerr++;
            $display("FAIL reset_fields got %h %h %h exp 0",
                     dst_mac, src_mac, eth_type);
        end
        @(posedge clk);
        #1;
        h0 = hdr_n;
        e0 = eof_n;
        got_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) nib(1'b1, PREAMBLE_NIB);
        nib(1'b1, SFD_NIB);
        for (int i = 0; i < 80; i++) nib(1'b1, 4'($urandom));
        for (int i = 0; i < 8; i++) nib(1'b0, 4'h0);
        nchk++;
        if (hdr_n - h0 + eof_n - e0 + got_q.size() !== 0) begin
            nerr++;
            $display("FAIL reset_release_ignored got hdr=%0d eof=%0d bytes=%0d exp 0",
                     hdr_n - h0, eof_n - e0, got_q.size());
        end
    endtask

    task automatic test_basic();
        logic [7:0] h[14];
        h = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
              8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc,
              8'h12, 8'h34};
        make_frame(50);
        for (int i = 0; i < 14; i++) fr[i] = h[i];
        model(50, 1'b0);
        h0 = hdr_n;
        e0 = eof_n;
        got_q.delete();
        send(1'b0, -1);
        nchk++;
        if ({dst_mac, src_mac, eth_type} !== {48'h54ff01212324, 48'h123456789abc, 16'h1234}) begin
            nerr++;
            $display("FAIL basic_fields got %h %h %h", dst_mac, src_mac, eth_type);
        end
        nchk++;
        if (hdr_n - h0 !== 1 || eof_n - e0 !== 1) begin
            nerr++;
            $display("FAIL basic_strobes got hdr=%0d eof=%0d exp 1 1",
                     hdr_n - h0, eof_n - e0);
        end
        nchk++;
        if (pl_diff() !== 0 || got_q.size() !== 36) begin
            nerr++;
            $display("FAIL basic_payload got %0d bytes exp 36", got_q.size());
        end
        nchk++;
        if (eof_len !== 11'd50 || eof_err !== 3'b001) begin
            nerr++;
            $display("FAIL basic_eof got len=%0d err=%b exp 50 001", eof_len, eof_err);
        end
    endtask

    task automatic test_min();
        make_frame(64);
        model(64, 1'b0);
        e0 = eof_n;
        got_q.delete();
        send(1'b0, -1);
        nchk++;
        if (eof_n - e0 !== 1 || eof_len !== 11'd64 || eof_err !== 3'b000) begin
            nerr++;
            $display("FAIL min_eof got n=%0d len=%0d err=%b exp 1 64 000",
                     eof_n - e0, eof_len, eof_err);
        end
        nchk++;
        if (pl_diff() !== 0) begin
            nerr++;
            $display("FAIL min_payload got %0d bytes exp %0d", got_q.size(), exp_pl.size());
        end
    endtask

    task automatic test_align();
        make_frame(21);
        model(21, 1'b1);
        e0 = eof_n;
        got_q.delete();
        send(1'b1, -1);
        nchk++;
        if (eof_n - e0 !== 1 || eof_len !== 11'd21 || eof_err !== 3'b011) begin
            nerr++;
            $display("FAIL align_eof got n=%0d len=%0d err=%b exp 1 21 011",
                     eof_n - e0, eof_len, eof_err);
        end
        nchk++;
        if (pl_diff() !== 0) begin
            nerr++;
            $display("FAIL align_payload got %0d bytes exp %0d", got_q.size(), exp_pl.size());
        end
    endtask

    task automatic test_long();
        make_frame(1600);
        model(1600, 1'b0);
        e0 = eof_n;
        got_q.delete();
        send(1'b0, -1);
        nchk++;
        if (got_q.size() !== MAXL - 14 || pl_diff() !== 0) begin
            nerr++;
            $display("FAIL long_payload got %0d bytes exp %0d", got_q.size(), MAXL - 14);
        end
        nchk++;
        if (eof_n - e0 !== 1 || eof_len !== 11'd1519 || eof_err !== 3'b100) begin
            nerr++;
            $display("FAIL long_eof got n=%0d len=%0d err=%b exp 1 1519 100",
                     eof_n - e0, eof_len, eof_err);
        end
    endtask

    task automatic test_bad_preamble();
        h0 = hdr_n;
        e0 = eof_n;
        got_q.delete();
        nib(1'b1, 4'h5);
        nib(1'b1, 4'h5);
        nib(1'b1, 4'h7);
        nib(1'b1, SFD_NIB);
        for (int i = 0; i < 60; i++) nib(1'b1, 4'($urandom));
        for (int i = 0; i < 8; i++) nib(1'b0, 4'h0);
        nchk++;
        if (hdr_n - h0 + eof_n - e0 + got_q.size() !== 0) begin
            nerr++;
            $display("FAIL badpre_silent got hdr=%0d eof=%0d bytes=%0d exp 0",
                     hdr_n - h0, eof_n - e0, got_q.size());
        end
        make_frame(70);
        model(70, 1'b0);
        e0 = eof_n;
        send(1'b0, -1);
        nchk++;
        if (eof_n - e0 !== 1 || eof_len !== 11'd70 || eof_err !== 3'b000
            || pl_diff() !== 0) begin
            nerr++;
            $display("FAIL badpre_next got len=%0d err=%b bytes=%0d exp 70 000 %0d",
                     eof_len, eof_err, got_q.size(), exp_pl.size());
        end
    endtask

    task automatic test_reset_midframe();
        make_frame(60);
        got_q.delete();
        send(1'b0, 20);
        nchk++;
        if (hdr_n !== snap_h || eof_n !== snap_e || got_q.size() !== snap_p) begin
            nerr++;
            $display("FAIL rstmid_silent got hdr=%0d eof=%0d bytes=%0d exp %0d %0d %0d",
                     hdr_n, eof_n, got_q.size(), snap_h, snap_e, snap_p);
        end
        make_frame(80);
        model(80, 1'b0);
        h0 = hdr_n;
        e0 = eof_n;
        got_q.delete();
        send(1'b0, -1);
        nchk++;
        if (hdr_n - h0 !== 1 || eof_n - e0 !== 1 || eof_len !== 11'd80
            || eof_err !== 3'b000 || pl_diff() !== 0) begin
            nerr++;
            $display("FAIL rstmid_next got hdr=%0d eof=%0d len=%0d err=%b bytes=%0d",
                     hdr_n - h0, eof_n - e0, eof_len, eof_err, got_q.size());
        end
        nchk++;
        if ({dst_mac, src_mac, eth_type} !== {exp_dst, exp_src, exp_type}) begin
            nerr++;
            $display("FAIL rstmid_fields got %h %h %h exp %h %h %h",
                     dst_mac, src_mac, eth_type, exp_dst, exp_src, exp_type);
        end
    endtask

    task automatic test_random();
        int lens[8];
        int n;
        bit odd;
        lens = '{13, 14, 63, 64, 65, 0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            n   = (k < 5) ? lens[k] : int'($urandom_range(1, 200));
            odd = 1'($urandom);
            make_frame(n);
            model(n, odd);
            h0 = hdr_n;
            e0 = eof_n;
            got_q.delete();
            send(odd, -1);
            nchk++;
            if (eof_n - e0 !== 1 || eof_len !== 11'(exp_len) || eof_err !== exp_err) begin
                nerr++;
                $display("FAIL rand_eof n=%0d got cnt=%0d len=%0d err=%b exp 1 %0d %b",
                         n, eof_n - e0, eof_len, eof_err, exp_len, exp_err);
            end
            nchk++;
            if (hdr_n - h0 !== exp_hdr || pl_diff() !== 0) begin
                nerr++;
                $display("FAIL rand_data n=%0d got hdr=%0d bytes=%0d exp %0d %0d",
                         n, hdr_n - h0, got_q.size(), exp_hdr, exp_pl.size());
            end
            if (exp_hdr == 1) begin
                nchk++;
                if ({dst_mac, src_mac, eth_type} !== {exp_dst, exp_src, exp_type}) begin
                    nerr++;
                    $display("FAIL rand_fields n=%0d got %h %h %h", n,
                             dst_mac, src_mac, eth_type);
                end
            end
        end
        nchk++;
        if (clash_n !== 0) begin
            nerr++;
            $display("FAIL eof_valid_overlap got %0d exp 0", clash_n);
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.d  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_min();
        test_align();
        test_long();
        test_bad_preamble();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
